ascensor_control: RTL

- Car-motion controller sitting directly downstream of the per-floor request registers.
- Consumes their pending-request flags and chooses the travel direction with a collective (SCAN) policy.
- Times floor-to-floor travel and door dwell, and pulses a per-floor "serviced" clear back to the request registers.
- Produces the current floor and the moving/stopped status those registers compare against.

---
 rtl/ascensor_control.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ascensor_control.sv
// ascensor_control -- elevator car-motion controller (collective / SCAN policy)
//
// Sits directly downstream of the per-floor request registers. It reads their
// pending flags, picks the travel direction, times floor-to-floor travel and
// door dwell, and pulses a per-floor "serviced" clear back to the registers.
//
// Optional feature macro: ASCENSOR_SSEG_EN
//   defined   -> adds the sseg port, a registered 7-segment decode of the floor
//   undefined -> no sseg port and no decoder logic
//
// Ports:
//   clk             in   system clock (100 MHz)
//   reset           in   asynchronous, active-low reset
//   pending         in   [NUM_FLOORS] outstanding request per floor (level)
//   serviced        out  [NUM_FLOORS] one-clk pulse on the floor whose door opens
//   piso_actual     out  [FLOOR_W] current floor index
//   estado_ascensor out  1 = moving, 0 = stopped
//   dir_up          out  1 = current or last direction is up
//   puerta_abierta  out  door open
//   sseg            out  [7] active-low segments, bit 6 = a ... bit 0 = g,
//                        so "0" reads 7'b0000001 (only with ASCENSOR_SSEG_EN)

module ascensor_control #(
    parameter int NUM_FLOORS   = 4,
    parameter int FLOOR_W      = 2,
    parameter int TICK_DIV     = 50_000_000,
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] pending,
    output logic [NUM_FLOORS-1:0] serviced,
    output logic [FLOOR_W-1:0]    piso_actual,
    output logic                  estado_ascensor,
    output logic                  dir_up,
    output logic                  puerta_abierta
`ifdef ASCENSOR_SSEG_EN
    ,
    output logic [6:0]            sseg
`endif
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TRV_W  = $clog2(TRAVEL_TICKS + 1);
    localparam int DOOR_W = $clog2(DOOR_TICKS + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [TRV_W-1:0]   TRV_LAST  = TRV_W'(TRAVEL_TICKS - 1);
    localparam logic [DOOR_W-1:0]  DOOR_LAST = DOOR_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_ARRIVE,
        S_DOOR
    } state_t;

    state_t               state, state_nx;
    logic [PRE_W-1:0]     prescaler;
    logic                 tick;
    logic [TRV_W-1:0]     travel_cnt, travel_nx;
    logic [DOOR_W-1:0]    door_cnt, door_nx;
    logic [FLOOR_W-1:0]   piso_nx;
    logic                 dir_nx;
    logic [NUM_FLOORS-1:0] serviced_nx;
    logic                 above, below, here;
    logic                 here_q;
    logic                 go_up, go_down;

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i == int'(f)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Free-running prescaler; tick is a single-cycle enable, not a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    assign tick = (prescaler == PRE_LAST);

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        here  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i]) begin
                if (i > int'(piso_actual)) above = 1'b1;
                if (i < int'(piso_actual)) below = 1'b1;
                if (i == int'(piso_actual)) here = 1'b1;
            end
        end
    end

    // Keep the current direction while it still has work; otherwise turn.
    // The same rule covers idle start, arrival and leaving the door.
    assign go_up   = above && (dir_up || !below);
    assign go_down = below && !go_up;

    always_comb begin
        state_nx    = state;
        piso_nx     = piso_actual;
        dir_nx      = dir_up;
        travel_nx   = travel_cnt;
        door_nx     = door_cnt;
        serviced_nx = '0;
        unique case (state)
            S_IDLE, S_ARRIVE: begin
                if (here) begin
                    state_nx    = S_DOOR;
                    serviced_nx = floor_onehot(piso_actual);
                    door_nx     = '0;
                end else if (go_up) begin
                    state_nx  = S_UP;
                    dir_nx    = 1'b1;
                    travel_nx = '0;
                end else if (go_down) begin
                    state_nx  = S_DOWN;
                    dir_nx    = 1'b0;
                    travel_nx = '0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            // A hop always completes, whatever pending does meanwhile.
            S_UP: begin
                if (tick) begin
                    if (travel_cnt == TRV_LAST) begin
                        travel_nx = '0;
                        state_nx  = S_ARRIVE;
                        if (piso_actual != TOP_FLOOR) piso_nx = piso_actual + FLOOR_W'(1);
                    end else begin
                        travel_nx = travel_cnt + TRV_W'(1);
                    end
                end
            end
            S_DOWN: begin
                if (tick) begin
                    if (travel_cnt == TRV_LAST) begin
                        travel_nx = '0;
                        state_nx  = S_ARRIVE;
                        if (piso_actual != '0) piso_nx = piso_actual - FLOOR_W'(1);
                    end else begin
                        travel_nx = travel_cnt + TRV_W'(1);
                    end
                end
            end
            // Only a fresh rising edge of the local request re-opens the door;
            // the level that brought us here is still high for a cycle or two
            // until the request register sees the serviced pulse.
            S_DOOR: begin
                if (here && !here_q) begin
                    serviced_nx = floor_onehot(piso_actual);
                    door_nx     = '0;
                end else if (tick) begin
                    if (door_cnt == DOOR_LAST) begin
                        door_nx  = '0;
                        state_nx = S_IDLE;
                    end else begin
                        door_nx = door_cnt + DOOR_W'(1);
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            piso_actual <= '0;
            dir_up      <= 1'b1;
            serviced    <= '0;
            travel_cnt  <= '0;
            door_cnt    <= '0;
            here_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            piso_actual <= piso_nx;
            dir_up      <= dir_nx;
            serviced    <= serviced_nx;
            travel_cnt  <= travel_nx;
            door_cnt    <= door_nx;
            here_q      <= here;
        end
    end

    // ARRIVE still counts as moving, so the two flags never overlap.
    assign estado_ascensor = (state == S_UP) || (state == S_DOWN) || (state == S_ARRIVE);
    assign puerta_abierta  = (state == S_DOOR);

`ifdef ASCENSOR_SSEG_EN
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sseg <= 7'b0000001;
        end else begin
            sseg <= seg_decode(4'(piso_actual));
        end
    end
`endif

endmodule
